// File: rtl/pll_lock_mgr.sv
// Per-channel PLL supervisor: pulses PLL reset, debounces LOCK, retries on timeout,
// latches a fault after the retries run out, and counts lock losses.
module pll_lock_mgr #(
    parameter int NUM_PLL          = 2,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int MAX_RETRY        = 3
) (
    input  logic                   clkin1,
    input  logic                   rst,
    input  logic [NUM_PLL-1:0]     pll_lock,
    input  logic [NUM_PLL-1:0]     relock_req,
    output logic [NUM_PLL-1:0]     pll_rst,
    output logic [NUM_PLL-1:0]     user_rst,
    output logic [NUM_PLL-1:0]     locked,
    output logic                   locked_all,
    output logic [NUM_PLL-1:0]     fault,
    output logic [8*NUM_PLL-1:0]   lost_cnt
);
    localparam int PW = $clog2(RST_PULSE_CYC + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        ST_RESET, ST_WAIT, ST_STABLE, ST_LOCKED, ST_FAULT
    } state_t;

    // pll_lock is asynchronous to clkin1
    logic [NUM_PLL-1:0] sync1_q, sync2_q;

    always_ff @(posedge clkin1) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
        end
    end

    assign locked_all = &locked;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLL; gi++) begin : g_ch
            state_t          state_q, state_d;
            logic [PW-1:0]   pulse_q, pulse_d;
            logic [SW-1:0]   stab_q,  stab_d;
            logic [TW-1:0]   tmo_q,   tmo_d;
            logic [RW-1:0]   retry_q, retry_d;
            logic [7:0]      lost_q,  lost_d;
            logic            lock_s;

            assign lock_s = sync2_q[gi];

            always_ff @(posedge clkin1) begin
                if (rst) begin
                    state_q <= ST_RESET;
                    pulse_q <= '0;
                    stab_q  <= '0;
                    tmo_q   <= '0;
                    retry_q <= '0;
                    lost_q  <= '0;
                end else begin
                    state_q <= state_d;
                    pulse_q <= pulse_d;
                    stab_q  <= stab_d;
                    tmo_q   <= tmo_d;
                    retry_q <= retry_d;
                    lost_q  <= lost_d;
                end
            end

            always_comb begin
                state_d = state_q;
                pulse_d = pulse_q;
                stab_d  = stab_q;
                tmo_d   = tmo_q;
                retry_d = retry_q;
                lost_d  = lost_q;
                case (state_q)
                    ST_RESET: begin
                        if (pulse_q == PW'(RST_PULSE_CYC - 1)) begin
                            state_d = ST_WAIT;
                            tmo_d   = '0;
                        end else begin
                            pulse_d = pulse_q + PW'(1);
                        end
                    end
                    ST_WAIT, ST_STABLE: begin
                        // Lock completion takes priority over a coincident timeout
                        if (state_q == ST_STABLE && lock_s &&
                            stab_q == SW'(LOCK_STABLE_CYC - 1)) begin
                            state_d = ST_LOCKED;
                        end else if (tmo_q == TW'(LOCK_TIMEOUT_CYC - 1)) begin
                            if (retry_q < RW'(MAX_RETRY)) begin
                                retry_d = retry_q + RW'(1);
                                state_d = ST_RESET;
                                pulse_d = '0;
                            end else begin
                                state_d = ST_FAULT;
                            end
                        end else begin
                            tmo_d = tmo_q + TW'(1);
                            if (state_q == ST_WAIT) begin
                                if (lock_s) begin
                                    state_d = ST_STABLE;
                                    stab_d  = '0;
                                end
                            end else if (!lock_s) begin
                                state_d = ST_WAIT;
                            end else begin
                                stab_d = stab_q + SW'(1);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        retry_d = '0;
                        if (!lock_s) begin
                            state_d = ST_RESET;
                            pulse_d = '0;
                            if (lost_q != 8'hFF) begin
                                lost_d = lost_q + 8'd1;
                            end
                        end
                    end
                    ST_FAULT: begin
                        state_d = ST_FAULT;
                    end
                    default: begin
                        state_d = ST_RESET;
                        pulse_d = '0;
                    end
                endcase
                if (relock_req[gi]) begin
                    state_d = ST_RESET;
                    pulse_d = '0;
                    retry_d = '0;
                    lost_d  = lost_q;
                end
            end

            assign pll_rst[gi]          = (state_q == ST_RESET) || (state_q == ST_FAULT);
            assign user_rst[gi]         = (state_q != ST_LOCKED);
            assign locked[gi]           = (state_q == ST_LOCKED);
            assign fault[gi]            = (state_q == ST_FAULT);
            assign lost_cnt[8*gi +: 8]  = lost_q;
        end
    endgenerate
endmodule

// File: tb/tb_pll_lock_mgr.sv
// Scoreboard bench for pll_lock_mgr: stimulus queues edge-stamped expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_pll_lock_mgr;
    localparam int SIG_PRST = 0, SIG_URST = 1, SIG_LOCK = 2, SIG_LALL = 3,
                   SIG_FLT = 4, SIG_LOST = 5;

    logic        clkin1 = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pll_lock = 2'b00;
    logic [1:0]  relock_req = 2'b00;
    logic [1:0]  pll_rst, user_rst, locked, fault;
    logic        locked_all;
    logic [15:0] lost_cnt;

    pll_lock_mgr #(
        .NUM_PLL(2), .RST_PULSE_CYC(4), .LOCK_STABLE_CYC(8),
        .LOCK_TIMEOUT_CYC(64), .MAX_RETRY(2)
    ) dut (
        .clkin1(clkin1), .rst(rst), .pll_lock(pll_lock), .relock_req(relock_req),
        .pll_rst(pll_rst), .user_rst(user_rst), .locked(locked),
        .locked_all(locked_all), .fault(fault), .lost_cnt(lost_cnt)
    );

    always #5 clkin1 = ~clkin1;

    int cyc = 0;
    always @(posedge clkin1) cyc <= cyc + 1;

    typedef struct {
        int          edge_n;
        int          sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   base = 0;

    task automatic push(input int rel, input int sig, input logic [15:0] val, input string name);
        exp_t e;
        e.edge_n = base + rel;
        e.sig    = sig;
        e.val    = val;
        e.name   = name;
        exp_q.push_back(e);
    endtask

    function automatic logic [15:0] actual(input int sig);
        case (sig)
            SIG_PRST: return {14'd0, pll_rst};
            SIG_URST: return {14'd0, user_rst};
            SIG_LOCK: return {14'd0, locked};
            SIG_LALL: return {15'd0, locked_all};
            SIG_FLT:  return {14'd0, fault};
            default:  return lost_cnt;
        endcase
    endfunction

    always @(negedge clkin1) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].edge_n <= cyc) begin
                logic [15:0] a;
                a = actual(exp_q[i].sig);
                total++;
                if (exp_q[i].edge_n < cyc) begin
                    bad++;
                    $display("FAIL %s: expectation for edge %0d missed (now %0d)",
                             exp_q[i].name, exp_q[i].edge_n - base, cyc - base);
                end else if (a !== exp_q[i].val) begin
                    bad++;
                    $display("FAIL %s @edge %0d: got %h want %h",
                             exp_q[i].name, cyc - base, a, exp_q[i].val);
                end else begin
                    $display("ok   %s @edge %0d: %h", exp_q[i].name, cyc - base, a);
                end
                exp_q.delete(i);
            end
        end
    end

    // Returns at the negedge following edge base+rel; inputs set here are sampled at base+rel+1
    task automatic wait_to(input int rel);
        while (cyc < base + rel) @(negedge clkin1);
    endtask

    task automatic push_reset_state(input int rel, input string tag);
        push(rel, SIG_PRST, 16'h0003, {tag, "_pll_rst"});
        push(rel, SIG_URST, 16'h0003, {tag, "_user_rst"});
        push(rel, SIG_LOCK, 16'h0000, {tag, "_locked"});
        push(rel, SIG_LALL, 16'h0000, {tag, "_locked_all"});
        push(rel, SIG_FLT,  16'h0000, {tag, "_fault"});
        push(rel, SIG_LOST, 16'h0000, {tag, "_lost_cnt"});
    endtask

    initial begin
        int k;
        logic [7:0] sat;
        // rst high at edges 1..3; edge 3 is edge 0 of the sequence
        base = 3;
        push_reset_state(0, "rst0");
        push(3,   SIG_PRST, 16'h0003, "t1_pulse_last");
        push(4,   SIG_PRST, 16'h0000, "t1_pulse_end");
        push(4,   SIG_URST, 16'h0003, "t1_user_rst");
        // ch0 glitchy lock, timeout retry at 68
        push(30,  SIG_LOCK, 16'h0000, "t3_no_lock");
        push(67,  SIG_PRST, 16'h0000, "t3_pre_tmo");
        push(68,  SIG_PRST, 16'h0003, "t3_retry_pulse");
        push(71,  SIG_PRST, 16'h0003, "t3_retry_last");
        push(72,  SIG_PRST, 16'h0000, "t3_retry_end");
        // ch0 clean lock sampled at 100
        push(109, SIG_LOCK, 16'h0000, "t2_pre_lock");
        push(110, SIG_LOCK, 16'h0001, "t2_locked0");
        push(110, SIG_URST, 16'h0002, "t2_user_rst");
        push(110, SIG_LALL, 16'h0000, "t2_lall_low");
        // ch1 never locks: third pulse then fault
        push(135, SIG_PRST, 16'h0000, "t4_pre_pulse3");
        push(136, SIG_PRST, 16'h0002, "t4_pulse3");
        push(140, SIG_PRST, 16'h0000, "t4_pulse3_end");
        push(203, SIG_FLT,  16'h0000, "t4_pre_fault");
        push(204, SIG_FLT,  16'h0002, "t4_fault");
        push(204, SIG_PRST, 16'h0002, "t4_fault_prst");
        push(250, SIG_FLT,  16'h0002, "t4_fault_hold");
        push(250, SIG_PRST, 16'h0002, "t4_prst_hold");
        push(260, SIG_FLT,  16'h0000, "t4_relock_clr");
        push(260, SIG_PRST, 16'h0002, "t4_relock_pulse");
        push(263, SIG_PRST, 16'h0002, "t4_relock_last");
        push(264, SIG_PRST, 16'h0000, "t4_relock_end");
        push(309, SIG_LALL, 16'h0000, "t4_pre_lall");
        push(310, SIG_LOCK, 16'h0003, "t4_both_locked");
        push(310, SIG_LALL, 16'h0001, "t4_lall");
        push(310, SIG_URST, 16'h0000, "t4_user_rst");

        wait_to(0);   rst = 1'b0;
        wait_to(19);  pll_lock[0] = 1'b1;
        wait_to(24);  pll_lock[0] = 1'b0;
        wait_to(99);  pll_lock[0] = 1'b1;
        wait_to(259); relock_req[1] = 1'b1;
        wait_to(260); relock_req[1] = 1'b0;
        wait_to(299); pll_lock[1] = 1'b1;

        // repeated lock loss on ch0, lost_cnt must saturate
        for (int i = 0; i < 300; i++) begin
            k = 340 + 20 * i;
            sat = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            wait_to(k - 1);
            push(k + 1, SIG_LOCK, 16'h0003, "t5_still_locked");
            push(k + 2, SIG_LOCK, 16'h0002, "t5_lost");
            push(k + 2, SIG_PRST, 16'h0001, "t5_new_pulse");
            push(k + 2, SIG_LOST, {8'd0, sat}, "t5_lost_cnt");
            pll_lock[0] = 1'b0;
            wait_to(k + 5);
            pll_lock[0] = 1'b1;
        end

        // reset while both channels are locked
        k = 6360;
        push(k - 1, SIG_LOCK, 16'h0003, "t6_pre_locked");
        push(k - 1, SIG_LOST, 16'h00FF, "t6_pre_lost");
        wait_to(k - 1);
        rst = 1'b1;
        pll_lock = 2'b00;
        wait_to(k);
        rst = 1'b0;
        base = base + k;
        push_reset_state(0, "t6_rst");
        push(3,  SIG_PRST, 16'h0003, "t6_pulse_last");
        push(4,  SIG_PRST, 16'h0000, "t6_pulse_end");
        push(10, SIG_URST, 16'h0003, "t6_user_rst");
        wait_to(20);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
